// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
//   Shared constants for the mux leaf block.
//   Holds the minimum legal data width so the elaboration check in mux and
//   any wrapper that sizes a mux from a computed width agree on one value.
// Ports: none (package).
// -----------------------------------------------------------------------------
package mux_pkg;

    // Smallest data width a mux instance may be built with.
    localparam int MIN_WIDTH = 1;

endpackage : mux_pkg

// File: rtl/mux.sv
// -----------------------------------------------------------------------------
// mux
//   Parameterised 2:1 multiplexer. This block has two outputs:
//   - y is the combinational selection, with zero latency.
//   - y_q is a registered copy of that selection, for consumers that need a
//     flop boundary.
//   With WIDTH=1 the block is the plain 1-bit multiplexer.
//
// Parameters
//   WIDTH      data width of d0, d1, y, y_q (>= 1)
//   RESET_VAL  value loaded into y_q while rst is high
//
// Ports
//   clk   in   1      rising-edge clock for y_q
//   rst   in   1      synchronous, active-high reset of y_q; takes priority over en
//   d0    in   WIDTH  data selected when s=0
//   d1    in   WIDTH  data selected when s=1
//   s     in   1      select
//   en    in   1      load enable for y_q
//   y     out  WIDTH  combinational output, s ? d1 : d0
//   y_q   out  WIDTH  registered output, one-cycle latency
// -----------------------------------------------------------------------------
module mux
    import mux_pkg::*;
#(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic             s,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
);

    // Reject an illegal width when the design is elaborated, not in silicon.
    if (WIDTH < MIN_WIDTH) begin : g_width_check
        $error("mux: WIDTH must be at least 1");
    end

    // A ternary operator is used so that an unknown s gives X on y in
    // simulation, where d0 and d1 differ. An if/else would silently pick d0.
    assign y = s ? d1 : d0;

    // y_q captures the same selection at the clock edge. rst is checked first
    // so that a reset clears the register even when en is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            y_q <= RESET_VAL;
        end else if (en) begin
            y_q <= s ? d1 : d0;
        end
    end

endmodule : mux

// File: tb/tb_mux.sv
// -----------------------------------------------------------------------------
// tb_mux
//   Directed testbench for mux. It uses two instances:
//   - a 1-bit instance, built with default parameters;
//   - an 8-bit instance.
//   Each scenario task drives its own stimulus and compares the outputs
//   against hand-computed values.
// -----------------------------------------------------------------------------
module tb_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 1-bit instance signals
    logic rst1, d0_1, d1_1, s1, en1;
    logic y1, yq1;

    // 8-bit instance signals
    logic       rst8, s8, en8;
    logic [7:0] d0_8, d1_8, y8, yq8;

    int checks   = 0;
    int failures = 0;

    mux u_mux1 (
        .clk (clk),
        .rst (rst1),
        .d0  (d0_1),
        .d1  (d1_1),
        .s   (s1),
        .en  (en1),
        .y   (y1),
        .y_q (yq1)
    );

    mux #(.WIDTH(8), .RESET_VAL(8'h00)) u_mux8 (
        .clk (clk),
        .rst (rst8),
        .d0  (d0_8),
        .d1  (d1_8),
        .s   (s8),
        .en  (en8),
        .y   (y8),
        .y_q (yq8)
    );

    // Advance to just after the next rising edge. Outputs are sampled here,
    // and new inputs are applied here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Both registers are reset with en high and both inputs at 1, so reset
    // must win over en. y keeps following the selected input throughout.
    task automatic test_reset();
        rst1 = 1'b1; en1 = 1'b1; d0_1 = 1'b1; d1_1 = 1'b1; s1 = 1'b0;
        rst8 = 1'b1; en8 = 1'b1; d0_8 = 8'hFF; d1_8 = 8'hFF; s8 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (yq1 !== 1'b0) begin
                failures++;
                $display("FAIL reset_yq1 cycle %0d: got %b want 0", i, yq1);
            end
            checks++;
            if (y1 !== 1'b1) begin
                failures++;
                $display("FAIL reset_y1 cycle %0d: got %b want 1", i, y1);
            end
            checks++;
            if (yq8 !== 8'h00) begin
                failures++;
                $display("FAIL reset_yq8 cycle %0d: got %h want 00", i, yq8);
            end
        end
        rst1 = 1'b0;
        rst8 = 1'b0;
    endtask

    // Step {d0,d1,s} through 000..111 every 10 ns and check y each step.
    task automatic test_truth_table();
        logic [7:0] exp_y;
        exp_y = 8'b1101_1000;  // bit k = expected y for {d0,d1,s} == k
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v;
            v = 3'(k);
            {d0_1, d1_1, s1} = v;
            #1;
            checks++;
            if (y1 !== exp_y[k]) begin
                failures++;
                $display("FAIL truth_table %b: got y=%b want %b", v, y1, exp_y[k]);
            end
            #9;
        end
    endtask

    // Toggle s every cycle with d0=0 and d1=1. y_q must lag y by exactly
    // one clock.
    task automatic test_latency();
        logic prev_y;
        en1 = 1'b1; d0_1 = 1'b0; d1_1 = 1'b1; s1 = 1'b0;
        tick();
        prev_y = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s1 = ~s1;
            #1;
            checks++;
            if (y1 !== s1) begin
                failures++;
                $display("FAIL latency_y step %0d: got %b want %b", i, y1, s1);
            end
            checks++;
            if (yq1 !== prev_y) begin
                failures++;
                $display("FAIL latency_pre step %0d: got y_q=%b want %b", i, yq1, prev_y);
            end
            prev_y = s1;
            tick();
            checks++;
            if (yq1 !== prev_y) begin
                failures++;
                $display("FAIL latency_post step %0d: got y_q=%b want %b", i, yq1, prev_y);
            end
        end
    endtask

    // With en=0, y_q holds while the inputs change. Once en returns high,
    // y_q loads on the next edge.
    task automatic test_enable_hold();
        en1 = 1'b1; s1 = 1'b1; d1_1 = 1'b1; d0_1 = 1'b0;
        tick();
        en1 = 1'b0; s1 = 1'b0; d0_1 = 1'b0; d1_1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (yq1 !== 1'b1) begin
                failures++;
                $display("FAIL enable_hold cycle %0d: got y_q=%b want 1", i, yq1);
            end
            d1_1 = ~d1_1;  // wiggle the unselected input as well
        end
        checks++;
        if (y1 !== 1'b0) begin
            failures++;
            $display("FAIL enable_hold_y: got y=%b want 0", y1);
        end
        en1 = 1'b1;
        tick();
        checks++;
        if (yq1 !== 1'b0) begin
            failures++;
            $display("FAIL enable_reload: got y_q=%b want 0", yq1);
        end
    endtask

    // 8-bit selection, and y_q following one cycle later.
    task automatic test_wide();
        en8 = 1'b1; d0_8 = 8'hA5; d1_8 = 8'h3C; s8 = 1'b0;
        #1;
        checks++;
        if (y8 !== 8'hA5) begin
            failures++;
            $display("FAIL wide_y_s0: got %h want a5", y8);
        end
        tick();
        checks++;
        if (yq8 !== 8'hA5) begin
            failures++;
            $display("FAIL wide_yq_s0: got %h want a5", yq8);
        end
        s8 = 1'b1;
        #1;
        checks++;
        if (y8 !== 8'h3C) begin
            failures++;
            $display("FAIL wide_y_s1: got %h want 3c", y8);
        end
        checks++;
        if (yq8 !== 8'hA5) begin
            failures++;
            $display("FAIL wide_yq_pre: got %h want a5", yq8);
        end
        tick();
        checks++;
        if (yq8 !== 8'h3C) begin
            failures++;
            $display("FAIL wide_yq_s1: got %h want 3c", yq8);
        end
    endtask

    // Reset for one edge in the middle of a stream: y_q clears on that edge
    // and reloads on the next, while y is unaffected by rst.
    task automatic test_reset_mid();
        en8 = 1'b1; s8 = 1'b1; d1_8 = 8'hFF; d0_8 = 8'h12;
        tick();
        checks++;
        if (yq8 !== 8'hFF) begin
            failures++;
            $display("FAIL mid_pre: got %h want ff", yq8);
        end
        rst8 = 1'b1;
        tick();
        checks++;
        if (yq8 !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset: got %h want 00", yq8);
        end
        checks++;
        if (y8 !== 8'hFF) begin
            failures++;
            $display("FAIL mid_y: got %h want ff", y8);
        end
        rst8 = 1'b0;
        tick();
        checks++;
        if (yq8 !== 8'hFF) begin
            failures++;
            $display("FAIL mid_reload: got %h want ff", yq8);
        end
    endtask

    // A new vector every cycle, with s and data changing together. Each
    // edge must capture the settled selection of that cycle.
    task automatic test_back_to_back();
        logic [7:0] v0 [6];
        logic [7:0] v1 [6];
        logic       vs [6];
        logic [7:0] ve [6];
        v0 = '{8'h01, 8'h80, 8'h55, 8'hF0, 8'h00, 8'h7E};
        v1 = '{8'hFE, 8'h11, 8'hAA, 8'h0F, 8'hC3, 8'h81};
        vs = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b1,  1'b0};
        ve = '{8'h01, 8'h11, 8'hAA, 8'hF0, 8'hC3, 8'h7E};
        en8 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d0_8 = v0[i]; d1_8 = v1[i]; s8 = vs[i];
            tick();
            checks++;
            if (yq8 !== ve[i]) begin
                failures++;
                $display("FAIL b2b vec %0d: got y_q=%h want %h", i, yq8, ve[i]);
            end
        end
    endtask

    initial begin
        rst1 = 1'b0; d0_1 = 1'b0; d1_1 = 1'b0; s1 = 1'b0; en1 = 1'b0;
        rst8 = 1'b0; d0_8 = 8'h00; d1_8 = 8'h00; s8 = 1'b0; en8 = 1'b0;
        #2;
        test_reset();
        test_truth_table();
        tick();
        test_latency();
        test_enable_hold();
        test_wide();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mux
